// File: rtl/ysyx_25040111_mem_arbiter_pkg.sv
// Shared encodings for the LSU port arbiter: FSM states, owner IDs and the
// full-word mask that fetch refills always use.
package ysyx_25040111_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2,
        ARB_NOP   = 2'd3
    } arb_state_e;

    localparam logic       OWN_IF = 1'b0;
    localparam logic       OWN_LS = 1'b1;
    localparam logic [1:0] MASK_W = 2'b11;

endpackage

// File: rtl/ysyx_25040111_mem_arbiter_rr_pick.sv
// Two-way grant decision for the arbiter: a lone requester always wins, a tie
// goes to the data path (fixed priority) or to whoever did not own the port last.
module ysyx_25040111_rr_pick
    import ysyx_25040111_mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic if_req,
    input  logic ls_req,
    input  logic last_owner,
    output logic grant_ls
);

    logic tie_ls;

    assign tie_ls   = (FIXED_PRIO != 0) ? 1'b1 : (last_owner == OWN_IF);
    assign grant_ls = ls_req & (~if_req | tie_ls);

endmodule

// File: rtl/ysyx_25040111_mem_arbiter.sv
// Shares the single LSU master between I-cache refills and the load/store path.
// The owner keeps the port until its final beat or a watchdog abort.
module ysyx_25040111_mem_arbiter
    import ysyx_25040111_mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int TO_W       = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic [7:0]  if_len,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        ls_req,
    input  logic        ls_wen,
    input  logic        ls_ren,
    input  logic        ls_sign,
    input  logic [1:0]  ls_mask,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    output logic        mem_start,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic        mem_sign,
    output logic [1:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_tlen,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err,
    output logic [1:0]  dbg_state
);

    localparam logic [TO_W-1:0] WD_ONE = {{(TO_W-1){1'b0}}, 1'b1};

    arb_state_e        state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic              start_q, start_d;
    logic              wen_q, wen_d;
    logic              ren_q, ren_d;
    logic              sign_q, sign_d;
    logic [1:0]        mask_q, mask_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        tlen_q, tlen_d;
    logic [7:0]        beat_q, beat_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic              err_q, err_d;

    logic grant_ls;
    logic xfer;
    logic final_beat;
    logic timeout;

    ysyx_25040111_rr_pick #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_rr_pick (
        .if_req    (if_req),
        .ls_req    (ls_req),
        .last_owner(last_owner_q),
        .grant_ls  (grant_ls)
    );

    assign xfer       = (state_q == ARB_FETCH) || (state_q == ARB_DATA);
    assign final_beat = xfer && mem_valid && (beat_q == tlen_q);
    // A beat arriving on the last watchdog cycle still counts as progress.
    assign timeout    = xfer && !mem_valid && (wd_q == '1);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        start_d      = 1'b0;
        wen_d        = wen_q;
        ren_d        = ren_q;
        sign_d       = sign_q;
        mask_d       = mask_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        tlen_d       = tlen_q;
        beat_d       = beat_q;
        wd_d         = wd_q;
        ls_rdata_d   = ls_rdata_q;
        err_d        = err_q;
        case (state_q)
            ARB_IDLE: begin
                if (if_req || ls_req) begin
                    beat_d = 8'd0;
                    wd_d   = '0;
                    if (grant_ls) begin
                        // Store wins when both enables are set.
                        wen_d   = ls_wen;
                        ren_d   = ls_ren & ~ls_wen;
                        sign_d  = ls_sign;
                        mask_d  = ls_mask;
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                        tlen_d  = 8'd0;
                        if (!ls_wen && !ls_ren) begin
                            state_d = ARB_NOP;
                        end else begin
                            state_d = ARB_DATA;
                            start_d = 1'b1;
                        end
                    end else begin
                        wen_d   = 1'b0;
                        ren_d   = 1'b1;
                        sign_d  = 1'b0;
                        mask_d  = MASK_W;
                        addr_d  = if_addr;
                        wdata_d = 32'd0;
                        tlen_d  = if_len;
                        state_d = ARB_FETCH;
                        start_d = 1'b1;
                    end
                end
            end
            ARB_FETCH, ARB_DATA: begin
                if (mem_valid) begin
                    beat_d = beat_q + 8'd1;
                    wd_d   = '0;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
                if (final_beat || timeout) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = (state_q == ARB_DATA) ? OWN_LS : OWN_IF;
                    if (state_q == ARB_DATA) begin
                        ls_rdata_d = timeout ? 32'd0 : mem_rdata;
                    end
                    if (timeout) begin
                        err_d = 1'b1;
                    end
                end
            end
            ARB_NOP: begin
                state_d      = ARB_IDLE;
                last_owner_d = OWN_LS;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= OWN_LS;
            start_q      <= 1'b0;
            wen_q        <= 1'b0;
            ren_q        <= 1'b0;
            sign_q       <= 1'b0;
            mask_q       <= 2'b00;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            tlen_q       <= 8'd0;
            beat_q       <= 8'd0;
            wd_q         <= '0;
            ls_rdata_q   <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            start_q      <= start_d;
            wen_q        <= wen_d;
            ren_q        <= ren_d;
            sign_q       <= sign_d;
            mask_q       <= mask_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            tlen_q       <= tlen_d;
            beat_q       <= beat_d;
            wd_q         <= wd_d;
            ls_rdata_q   <= ls_rdata_d;
            err_q        <= err_d;
        end
    end

    assign mem_start = start_q;
    assign mem_wen   = wen_q;
    assign mem_ren   = ren_q;
    assign mem_sign  = sign_q;
    assign mem_mask  = mask_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_tlen  = tlen_q;
    assign busy      = (state_q != ARB_IDLE);
    assign err       = err_q;
    assign dbg_state = state_q;

    assign if_rvalid = (state_q == ARB_FETCH) && mem_valid;
    assign if_rdata  = (state_q == ARB_FETCH) ? mem_rdata : 32'd0;
    assign if_done   = (state_q == ARB_FETCH) && (final_beat || timeout);
    assign ls_done   = ((state_q == ARB_DATA) && (final_beat || timeout)) || (state_q == ARB_NOP);

    // Load data is presented alongside ls_done and then held from the register.
    always_comb begin
        ls_rdata = ls_rdata_q;
        if (state_q == ARB_DATA) begin
            if (final_beat) begin
                ls_rdata = mem_rdata;
            end else if (timeout) begin
                ls_rdata = 32'd0;
            end
        end
    end

endmodule
